cpu_wrapper_v3: RTL and testbench

- 8-bit accumulator-free register CPU core plus a unified program/data memory and a simple I/O port.
- Executes one instruction byte per clock, with no overlap between instructions; LDM takes two cycles.
- Top-level CPU block; the bench loads the memory through hierarchy and observes registers through hierarchy.

---
 rtl/cpu_v3_pkg.sv | 45 ++++
 rtl/cpu_v3_alu.sv | 90 +++++++++
 rtl/cpu_wrapper_v3.sv | 228 ++++++++++++++++++++++
 tb/tb_cpu_wrapper_v3.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_v3_pkg.sv
// Shared opcode, sub-op, flag-index and state definitions for the cpu_wrapper_v3 core.
package cpu_v3_pkg;

    localparam int SP_INDEX = 3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_SHF = 4'h6;
    localparam logic [3:0] OP_STK = 4'h7;
    localparam logic [3:0] OP_UNA = 4'h8;
    localparam logic [3:0] OP_RTI = 4'hB;
    localparam logic [3:0] OP_LDM = 4'hC;

    localparam logic [7:0] RTI_OPCODE = 8'hB0;

    localparam logic [1:0] SUB_RLC  = 2'd0;
    localparam logic [1:0] SUB_RRC  = 2'd1;
    localparam logic [1:0] SUB_SETC = 2'd2;
    localparam logic [1:0] SUB_CLRC = 2'd3;

    localparam logic [1:0] SUB_PUSH = 2'd0;
    localparam logic [1:0] SUB_POP  = 2'd1;
    localparam logic [1:0] SUB_OUT  = 2'd2;
    localparam logic [1:0] SUB_IN   = 2'd3;

    localparam logic [1:0] SUB_NOT = 2'd0;
    localparam logic [1:0] SUB_NEG = 2'd1;
    localparam logic [1:0] SUB_INC = 2'd2;
    localparam logic [1:0] SUB_DEC = 2'd3;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;
    localparam int CCR_V = 3;

    typedef enum logic {
        EXEC = 1'b0,
        IMM  = 1'b1
    } state_t;

endpackage

// File: rtl/cpu_v3_alu.sv
// Combinational ALU: two-operand ops use a=R[ra], b=R[rb]; single-operand groups act on b.
// flags_in supplies the carry-in and the flags that an op leaves untouched.
module cpu_v3_alu
    import cpu_v3_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    input  logic [1:0] sub_op,
    input  logic [3:0] flags_in,
    output logic [7:0] result,
    output logic       res_we,
    output logic [3:0] flags_out
);

    logic [8:0] add_sum;

    assign add_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result    = b;
        res_we    = 1'b0;
        flags_out = flags_in;

        case (op)
            OP_ADD: begin
                result           = add_sum[7:0];
                res_we           = 1'b1;
                flags_out[CCR_C] = add_sum[8];
                flags_out[CCR_V] = (a[7] == b[7]) && (add_sum[7] != a[7]);
            end
            OP_SUB: begin
                result           = a - b;
                res_we           = 1'b1;
                flags_out[CCR_C] = (a >= b);
                flags_out[CCR_V] = (a[7] != b[7]) && (result[7] != a[7]);
            end
            OP_AND: begin
                result = a & b;
                res_we = 1'b1;
            end
            OP_OR: begin
                result = a | b;
                res_we = 1'b1;
            end
            OP_SHF: begin
                case (sub_op)
                    SUB_RLC: begin
                        result           = {b[6:0], flags_in[CCR_C]};
                        res_we           = 1'b1;
                        flags_out[CCR_C] = b[7];
                    end
                    SUB_RRC: begin
                        result           = {flags_in[CCR_C], b[7:1]};
                        res_we           = 1'b1;
                        flags_out[CCR_C] = b[0];
                    end
                    SUB_SETC: flags_out[CCR_C] = 1'b1;
                    SUB_CLRC: flags_out[CCR_C] = 1'b0;
                    default: ;
                endcase
            end
            OP_UNA: begin
                res_we = 1'b1;
                case (sub_op)
                    SUB_NOT: result = ~b;
                    SUB_NEG: result = 8'd0 - b;
                    SUB_INC: begin
                        result           = b + 8'd1;
                        flags_out[CCR_C] = (b == 8'hFF);
                        flags_out[CCR_V] = (b == 8'h7F);
                    end
                    SUB_DEC: begin
                        result           = b - 8'd1;
                        flags_out[CCR_C] = (b != 8'h00);
                        flags_out[CCR_V] = (b == 8'h80);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        if (res_we) begin
            flags_out[CCR_Z] = (result == 8'h00);
            flags_out[CCR_N] = result[7];
        end
    end

endmodule

// File: rtl/cpu_wrapper_v3.sv
// cpu_wrapper_v3: 8-bit four-register CPU with unified memory and one I/O port.
// Optional interrupt entry/return (RTI = 0xB0) is built only when CPU_INTR_EN is defined.
//
//   state | meaning
//   EXEC  | execute the instruction byte at PC (or take a pending interrupt)
//   IMM   | second LDM cycle: byte at PC is the immediate for the latched register
module cpu_wrapper_v3
    import cpu_v3_pkg::*;
#(
    parameter int         MEM_DEPTH  = 256,
    parameter logic [7:0] SP_INIT    = 8'hFF,
    parameter logic [7:0] INT_VECTOR = 8'hF0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] I_Port,
    input  logic       int_sig,
    output logic [7:0] O_Port
);

    state_t     state, state_nx;
    logic [7:0] IR;
    logic [3:0] op;
    logic [1:0] ra, rb;
    logic [1:0] ldm_dst;
    logic [7:0] pc, pc_next;
    logic [7:0] reg_a, reg_b, sp, data_rd;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       sp_we;
    logic [7:0] sp_wdata;
    logic       ccr_we;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       out_we;
    logic       take_int;
    logic       rti_exec;

    logic [7:0] alu_res;
    logic       alu_res_we;
    logic [3:0] alu_flags;
    logic [3:0] ccr;

    if (1'b1) begin : mem_inst
        logic [7:0] mem [MEM_DEPTH];
        always_ff @(posedge clk) begin
            if (!rstn && mem_we) begin
                mem[sp] <= mem_wdata;
            end
        end
    end

    if (1'b1) begin : regfile_inst
        logic [7:0] regs [4];
        always_ff @(posedge clk) begin
            if (rstn) begin
                for (int i = 0; i < 4; i++) begin
                    regs[i] <= (i == SP_INDEX) ? SP_INIT : 8'h00;
                end
            end else begin
                // a register write to R3 (POP R3) deliberately overrides the SP update
                if (sp_we) regs[SP_INDEX] <= sp_wdata;
                if (rf_we) regs[rf_waddr] <= rf_wdata;
            end
        end
    end

    if (1'b1) begin : PC
        logic [7:0] pc_current;
        always_ff @(posedge clk) begin
            if (rstn) pc_current <= 8'h00;
            else      pc_current <= pc_next;
        end
    end

    if (1'b1) begin : ccr_inst
        logic [3:0] CCR;
        always_ff @(posedge clk) begin
            if (rstn)        CCR <= 4'h0;
            else if (ccr_we) CCR <= alu_flags;
        end
    end

    assign pc      = PC.pc_current;
    assign ccr     = ccr_inst.CCR;
    assign IR      = mem_inst.mem[pc];
    assign op      = IR[7:4];
    assign ra      = IR[3:2];
    assign rb      = IR[1:0];
    assign reg_a   = regfile_inst.regs[ra];
    assign reg_b   = regfile_inst.regs[rb];
    assign sp      = regfile_inst.regs[SP_INDEX];
    assign data_rd = mem_inst.mem[sp + 8'd1];

    cpu_v3_alu u_alu (
        .a         (reg_a),
        .b         (reg_b),
        .op        (op),
        .sub_op    (ra),
        .flags_in  (ccr),
        .result    (alu_res),
        .res_we    (alu_res_we),
        .flags_out (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= EXEC;
            ldm_dst <= 2'd0;
            O_Port  <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == EXEC && state_nx == IMM) ldm_dst <= rb;
            if (out_we) O_Port <= reg_b;
        end
    end

    always_comb begin
        state_nx  = EXEC;
        pc_next   = pc + 8'd1;
        rf_we     = 1'b0;
        rf_waddr  = rb;
        rf_wdata  = alu_res;
        sp_we     = 1'b0;
        sp_wdata  = sp;
        ccr_we    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = reg_b;
        out_we    = 1'b0;
        rti_exec  = 1'b0;

        if (state == IMM) begin
            rf_we    = 1'b1;
            rf_waddr = ldm_dst;
            rf_wdata = IR;
        end else if (take_int) begin
            mem_we    = 1'b1;
            mem_wdata = pc;
            sp_we     = 1'b1;
            sp_wdata  = sp - 8'd1;
            pc_next   = INT_VECTOR;
        end else begin
            case (op)
                OP_NOP: ;
                OP_MOV: begin
                    rf_we    = 1'b1;
                    rf_waddr = ra;
                    rf_wdata = reg_b;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    rf_we    = alu_res_we;
                    rf_waddr = ra;
                    ccr_we   = 1'b1;
                end
                OP_SHF, OP_UNA: begin
                    rf_we  = alu_res_we;
                    ccr_we = 1'b1;
                end
                OP_STK: begin
                    case (ra)
                        SUB_PUSH: begin
                            mem_we   = 1'b1;
                            sp_we    = 1'b1;
                            sp_wdata = sp - 8'd1;
                        end
                        SUB_POP: begin
                            rf_we    = 1'b1;
                            rf_wdata = data_rd;
                            sp_we    = 1'b1;
                            sp_wdata = sp + 8'd1;
                        end
                        SUB_OUT: out_we = 1'b1;
                        SUB_IN: begin
                            rf_we    = 1'b1;
                            rf_wdata = I_Port;
                        end
                        default: ;
                    endcase
                end
                OP_LDM: begin
                    if (ra == 2'd0) state_nx = IMM;
                end
`ifdef CPU_INTR_EN
                OP_RTI: begin
                    if (IR == RTI_OPCODE) begin
                        rti_exec = 1'b1;
                        sp_we    = 1'b1;
                        sp_wdata = sp + 8'd1;
                        pc_next  = data_rd;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef CPU_INTR_EN
    logic int_q, int_pend, int_mask;

    always_ff @(posedge clk) begin
        if (rstn) begin
            int_q    <= 1'b0;
            int_pend <= 1'b0;
            int_mask <= 1'b0;
        end else begin
            int_q <= int_sig;
            if (take_int) begin
                int_pend <= 1'b0;
                int_mask <= 1'b1;
            end else if (int_sig && !int_q) begin
                int_pend <= 1'b1;
            end
            if (rti_exec) int_mask <= 1'b0;
        end
    end

    assign take_int = (state == EXEC) && int_pend && !int_mask;
`else
    logic unused_intr;

    assign take_int    = 1'b0;
    assign unused_intr = ^{int_sig, INT_VECTOR, RTI_OPCODE, OP_RTI, rti_exec};
`endif

endmodule

// File: tb/tb_cpu_wrapper_v3.sv
// Self-checking bench for cpu_wrapper_v3: program is back-door loaded, expectations are queued
// against the PC value at which each result must be visible.
module tb_cpu_wrapper_v3;
    import cpu_v3_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] I_Port;
    logic       int_sig;
    logic [7:0] O_Port;

    cpu_wrapper_v3 dut (
        .clk     (clk),
        .rstn    (rstn),
        .I_Port  (I_Port),
        .int_sig (int_sig),
        .O_Port  (O_Port)
    );

    always #5 clk = ~clk;

    localparam int K_CCR = 4;
    localparam int K_OUT = 5;
    localparam int K_MEM = 6;
    localparam int K_PC  = 7;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ld_ptr;
    logic [7:0] exp_pc   [$];
    int         exp_kind [$];
    logic [7:0] exp_addr [$];
    logic [7:0] exp_val  [$];
    string      exp_tag  [$];

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] observe(input int kind, input logic [7:0] addr);
        case (kind)
            0, 1, 2, 3: observe = dut.regfile_inst.regs[kind];
            K_CCR:      observe = {4'h0, dut.ccr_inst.CCR};
            K_OUT:      observe = O_Port;
            K_MEM:      observe = dut.mem_inst.mem[addr];
            default:    observe = dut.PC.pc_current;
        endcase
    endfunction

    task automatic emit(input logic [7:0] b);
        dut.mem_inst.mem[ld_ptr] = b;
        ld_ptr = ld_ptr + 8'd1;
    endtask

    task automatic expect_at(input string tag, input int kind, input logic [7:0] addr,
                             input logic [7:0] val);
        exp_pc.push_back(ld_ptr);
        exp_kind.push_back(kind);
        exp_addr.push_back(addr);
        exp_val.push_back(val);
        exp_tag.push_back(tag);
    endtask

    initial begin
        int cyc;
        rstn    = 1'b1;
        int_sig = 1'b0;
        I_Port  = 8'h5A;
        for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = 8'h00;

        ld_ptr = 8'h00;
        emit(8'hC0); emit(8'h14); expect_at("ldm_r0", 0, 0, 8'h14);
        emit(8'hC1); emit(8'h32); expect_at("ldm_r1", 1, 0, 8'h32);
        emit(8'h00);
        emit(8'h24); expect_at("add_r1", 1, 0, 8'h46); expect_at("add_ccr", K_CCR, 0, 8'h00);
        emit(8'hC2); emit(8'h50); expect_at("ldm_r2", 2, 0, 8'h50);
        emit(8'h86); expect_at("neg_r2", 2, 0, 8'hB0); expect_at("neg_ccr", K_CCR, 0, 8'h02);
        emit(8'h00);
        emit(8'h36); expect_at("sub_r1", 1, 0, 8'h96); expect_at("sub_ccr", K_CCR, 0, 8'h0A);
        emit(8'h60); expect_at("rlc_r0", 0, 0, 8'h28); expect_at("rlc_ccr", K_CCR, 0, 8'h08);
        emit(8'h64); expect_at("rrc_r0", 0, 0, 8'h14); expect_at("rrc_ccr", K_CCR, 0, 8'h08);
        emit(8'h68); expect_at("setc_ccr", K_CCR, 0, 8'h0C);
        emit(8'h59); expect_at("or_r2", 2, 0, 8'hB6); expect_at("or_ccr", K_CCR, 0, 8'h0E);
        emit(8'h6C); expect_at("clrc_ccr", K_CCR, 0, 8'h0A);
        emit(8'h72); expect_at("push_mem", K_MEM, 8'hFF, 8'hB6); expect_at("push_sp", 3, 0, 8'hFE);
        emit(8'h8E); expect_at("dec1_r2", 2, 0, 8'hB5); expect_at("dec1_ccr", K_CCR, 0, 8'h06);
        emit(8'h8E); expect_at("dec2_r2", 2, 0, 8'hB4);
        emit(8'h76); expect_at("pop_r2", 2, 0, 8'hB6); expect_at("pop_sp", 3, 0, 8'hFF);
        emit(8'h80); expect_at("not_r0", 0, 0, 8'hEB); expect_at("not_ccr", K_CCR, 0, 8'h06);
        expect_at("final_r1", 1, 0, 8'h96);
        emit(8'h7D); expect_at("in_r1", 1, 0, 8'h5A);
        emit(8'h79); expect_at("out_port", K_OUT, 0, 8'h5A);
        emit(8'h35); expect_at("subz_r1", 1, 0, 8'h00); expect_at("subz_ccr", K_CCR, 0, 8'h05);
        emit(8'h8D); expect_at("dec0_r1", 1, 0, 8'hFF); expect_at("dec0_ccr", K_CCR, 0, 8'h02);
        emit(8'h89); expect_at("incff_r1", 1, 0, 8'h00); expect_at("incff_ccr", K_CCR, 0, 8'h05);
        emit(8'h9F); expect_at("undef_r1", 1, 0, 8'h00); expect_at("undef_ccr", K_CCR, 0, 8'h05);
        emit(8'h73); expect_at("pushsp_mem", K_MEM, 8'hFF, 8'hFF); expect_at("pushsp_sp", 3, 0, 8'hFE);
        emit(8'h75); expect_at("pop1_r1", 1, 0, 8'hFF);
        emit(8'h75); expect_at("popwrap_r1", 1, 0, 8'hC0); expect_at("popwrap_sp", 3, 0, 8'h00);
        emit(8'h71); expect_at("pushwrap_mem", K_MEM, 8'h00, 8'hC0); expect_at("pushwrap_sp", 3, 0, 8'hFF);
        emit(8'hC4);
        emit(8'hC1); emit(8'h7F); expect_at("ldm_after_c4", 1, 0, 8'h7F);
        emit(8'h25); expect_at("addv_r1", 1, 0, 8'hFE); expect_at("addv_ccr", K_CCR, 0, 8'h0A);

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pc", observe(K_PC, 0), 8'h00);
        check_val("rst_r0", observe(0, 0), 8'h00);
        check_val("rst_r1", observe(1, 0), 8'h00);
        check_val("rst_r2", observe(2, 0), 8'h00);
        check_val("rst_sp", observe(3, 0), 8'hFF);
        check_val("rst_ccr", observe(K_CCR, 0), 8'h00);
        check_val("rst_out", observe(K_OUT, 0), 8'h00);

        @(negedge clk) rstn = 1'b0;
        cyc = 0;
        while (exp_pc.size() > 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            while (exp_pc.size() > 0 && exp_pc[0] == dut.PC.pc_current) begin
                check_val(exp_tag[0], observe(exp_kind[0], exp_addr[0]), exp_val[0]);
                void'(exp_pc.pop_front());
                void'(exp_kind.pop_front());
                void'(exp_addr.pop_front());
                void'(exp_val.pop_front());
                void'(exp_tag.pop_front());
            end
        end
        if (exp_pc.size() > 0) check_val("sb_drain", 8'(exp_pc.size()), 8'h00);

        // reset asserted while an LDM waits for its immediate
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) rstn = 1'b0;
        @(posedge clk); #1;
        check_val("ldm_first_pc", observe(K_PC, 0), 8'h01);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        check_val("rst_imm_pc", observe(K_PC, 0), 8'h00);
        check_val("rst_imm_r0", observe(0, 0), 8'h00);
        check_val("rst_imm_state", {7'h00, dut.state}, 8'h00);
        @(negedge clk) rstn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("reldm_pc", observe(K_PC, 0), 8'h02);
        check_val("reldm_r0", observe(0, 0), 8'h14);

`ifdef CPU_INTR_EN
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = 8'h00;
        dut.mem_inst.mem[8'hF0] = 8'hB0;
        @(posedge clk);
        @(negedge clk) rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) int_sig = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) int_sig = 1'b0;
        @(posedge clk); #1;
        check_val("int_pc", observe(K_PC, 0), 8'hF0);
        check_val("int_ret_addr", observe(K_MEM, 8'hFF), 8'h04);
        check_val("int_sp", observe(3, 0), 8'hFE);
        @(posedge clk); #1;
        check_val("rti_pc", observe(K_PC, 0), 8'h04);
        check_val("rti_sp", observe(3, 0), 8'hFF);
        @(posedge clk); #1;
        check_val("post_rti_pc", observe(K_PC, 0), 8'h05);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
